// File: rtl/timer_ctrl.sv
// Programmable timer with prescaler, compare match, one-shot/periodic modes and a pending interrupt.
// Optional prescaler is built when TIMER_CTRL_PRESCALER_EN is defined; otherwise tick fires every RUN cycle.
module timer_ctrl #(
    parameter int COUNTER_WIDTH = 16,
    parameter int PRESC_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [1:0]               addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    output logic [COUNTER_WIDTH-1:0] val,
    output logic                     tick,
    output logic                     top_pulse,
    output logic                     irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic                     en_q, en_d;
    logic                     oneshot_q, oneshot_d;
    logic                     irq_en_q, irq_en_d;
    logic                     pending_q, pending_d;
    logic [COUNTER_WIDTH-1:0] cmp_q, cmp_d;
    logic [COUNTER_WIDTH-1:0] val_q, val_d;

    logic ctrl_wr;
    logic cmp_wr;
    logic status_wr;
    logic start;
    logic match;
    logic unused_wdata;

    assign ctrl_wr   = we && (addr == 2'd0);
    assign cmp_wr    = we && (addr == 2'd2);
    assign status_wr = we && (addr == 2'd3);
    assign start     = ctrl_wr && wdata[0];

    // Only the low bits of wdata carry register fields.
    assign unused_wdata = ^wdata;

`ifdef TIMER_CTRL_PRESCALER_EN
    logic                   presc_wr;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic [PRESC_WIDTH-1:0] pcnt_q, pcnt_d;

    assign presc_wr = we && (addr == 2'd1);
    assign tick     = (state_q == RUN) && (pcnt_q == presc_q);

    always_comb begin
        presc_d = presc_q;
        pcnt_d  = pcnt_q;
        if (presc_wr) begin
            presc_d = wdata[PRESC_WIDTH-1:0];
        end
        // A restart realigns the prescaler phase with the count.
        if (start) begin
            pcnt_d = '0;
        end else if ((state_q == RUN) && !ctrl_wr) begin
            pcnt_d = tick ? '0 : pcnt_q + PRESC_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_q <= '0;
            pcnt_q  <= '0;
        end else begin
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
        end
    end

    function automatic logic [31:0] presc_read(input logic [PRESC_WIDTH-1:0] p);
        return 32'(p);
    endfunction
`else
    // Without a prescaler the divider is effectively fixed at zero.
    localparam logic [PRESC_WIDTH-1:0] PRESC_FIXED = '0;

    assign tick = (state_q == RUN);

    function automatic logic [31:0] presc_read(input logic [PRESC_WIDTH-1:0] p);
        return 32'(p);
    endfunction
`endif

    assign match     = tick && (val_q == cmp_q);
    assign top_pulse = match;
    assign irq       = pending_q & irq_en_q;
    assign val       = val_q;

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        oneshot_d = oneshot_q;
        irq_en_d  = irq_en_q;
        cmp_d     = cmp_q;
        val_d     = val_q;

        // A CTRL write always decides the next state; otherwise a one-shot match retires the timer.
        if (ctrl_wr) begin
            en_d      = wdata[0];
            oneshot_d = wdata[1];
            irq_en_d  = wdata[2];
            state_d   = wdata[0] ? RUN : IDLE;
        end else if (match && oneshot_q) begin
            en_d    = 1'b0;
            state_d = DONE;
        end

        if (cmp_wr) begin
            cmp_d = wdata[COUNTER_WIDTH-1:0];
        end

        if (start) begin
            val_d = '0;
        end else if (!ctrl_wr && match) begin
            val_d = oneshot_q ? val_q : '0;
        end else if (!ctrl_wr && tick) begin
            val_d = val_q + COUNTER_WIDTH'(1);
        end

        // Hardware set takes priority over a software clear in the same cycle.
        pending_d = match | (pending_q & ~(status_wr & wdata[0]));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            en_q      <= 1'b0;
            oneshot_q <= 1'b0;
            irq_en_q  <= 1'b0;
            pending_q <= 1'b0;
            cmp_q     <= '0;
            val_q     <= '0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            oneshot_q <= oneshot_d;
            irq_en_q  <= irq_en_d;
            pending_q <= pending_d;
            cmp_q     <= cmp_d;
            val_q     <= val_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            2'd0: rdata = {29'd0, irq_en_q, oneshot_q, en_q};
`ifdef TIMER_CTRL_PRESCALER_EN
            2'd1: rdata = presc_read(presc_q);
`else
            2'd1: rdata = presc_read(PRESC_FIXED);
`endif
            2'd2: rdata = 32'(cmp_q);
            2'd3: rdata = {29'd0, state_q, pending_q};
            default: rdata = '0;
        endcase
    end

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter COUNTER_WIDTH, default 16: width of the count value and the compare register.
REQ-002 Parameter PRESC_WIDTH, default 8: width of the prescaler register.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 reset  input  1: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 we  input  1: register write strobe; one write per asserted cycle.
REQ-006 addr  input  2: register select: 0 CTRL, 1 PRESC, 2 CMP, 3 STATUS.
REQ-007 wdata  input  32: write data; unused upper bits ignored.
REQ-008 rdata  output  32: combinational read of the register at addr, zero-extended.
REQ-009 val  output  COUNTER_WIDTH: current count.
REQ-010 tick  output  1: one-cycle prescaled count-enable pulse.
REQ-011 top_pulse  output  1: one-cycle pulse on the tick where val equals CMP.
REQ-012 irq  output  1: interrupt level, equal to STATUS.pending AND CTRL.irq_en.

Function
REQ-013 CTRL fields SHALL be: bit0 enable, bit1 oneshot (0 periodic, 1 one-shot), bit2 irq_en; reads return all three bits.
REQ-014 STATUS SHALL read as {state[1:0] at bits 2:1, pending at bit0}; writing 1 to bit0 clears pending; writing 0 has no effect.
REQ-015 The FSM SHALL have three states, encoded IDLE=0, RUN=1, DONE=2.
REQ-016 IDLE->RUN SHALL occur on a CTRL write with enable=1; on the same edge val and the prescaler count are cleared to 0.
REQ-017 RUN->IDLE SHALL occur on a CTRL write with enable=0; val is held and no tick is generated in IDLE.
REQ-018 In RUN the prescaler count SHALL increment every cycle; when it equals PRESC, tick is asserted that cycle and the count returns to 0, so tick has period PRESC+1 cycles.
REQ-019 On tick with val!=CMP, val SHALL become val+1 modulo 2^COUNTER_WIDTH.
REQ-020 On tick with val==CMP, top_pulse SHALL be asserted in the same cycle and pending set on the next edge.
REQ-021 Periodic mode, on that match: val SHALL go to 0 and the FSM stays in RUN.
REQ-022 One-shot mode, on that match: val SHALL hold CMP, the FSM goes to DONE and CTRL.enable is cleared by hardware.
REQ-023 DONE SHALL hold val with no ticks; a CTRL write with enable=1 restarts as in REQ-016, and a write with enable=0 goes to IDLE.
REQ-024 A CMP or PRESC write during RUN SHALL take effect on the next cycle; if val already exceeds the new CMP, val wraps through 2^COUNTER_WIDTH before matching.
REQ-025 A pending set and a STATUS clear in the same cycle SHALL leave pending at 1 (set wins).
REQ-026 A CTRL write with enable=0 in the same cycle as a match tick SHALL still produce top_pulse and set pending, and the FSM goes to IDLE.
REQ-027 A CTRL write with enable=1 while in RUN SHALL restart the count at 0 (val and prescaler count cleared).

Reset
REQ-028 With reset low at a clock edge, the block SHALL enter IDLE and clear CTRL, PRESC, CMP, pending, val and the prescaler count to 0; tick, top_pulse and irq are 0.
REQ-029 Reset SHALL override any write in the same cycle, including mid-count in RUN.

Configuration
REQ-030 Macro TIMER_CTRL_PRESCALER_EN defined: the prescaler behaves as in REQ-018.
REQ-031 Macro TIMER_CTRL_PRESCALER_EN undefined: no prescaler logic; tick equals 1 every RUN cycle; PRESC reads 0 and writes to it are ignored.

Verification
REQ-032 PRESC=1, CMP=3, periodic, enable -> tick every 2nd cycle; val sequence 0,1,2,3,0; top_pulse one cycle when val=3; pending=1 afterwards.
REQ-033 PRESC=0, CMP=2, oneshot, irq_en=1 -> after 3 ticks, state=DONE, val=2, CTRL reads 0b110, irq=1; STATUS write of 1 -> irq=0.
REQ-034 Pending set and STATUS clear in the same cycle -> pending remains 1; clear on a later cycle -> 0.
REQ-035 Running with val=5, write CMP=2 -> val counts up to 2^16-1, wraps to 0, then top_pulse at val=2.
REQ-036 reset driven low mid-RUN with val=7 -> next edge: val=0, state=IDLE, all registers 0, irq=0.
REQ-037 Build without TIMER_CTRL_PRESCALER_EN, write PRESC=5, CMP=1 -> PRESC reads 0; tick asserted every RUN cycle; top_pulse every 2 cycles.
